// File: rtl/game_types_pkg.sv
// Shared types for the code-guessing game: state encoding, digit width and
// the default guess allowance.
package game_types;

  localparam int DIGIT_W             = 4;
  localparam int DEFAULT_MAX_CHANCES = 5;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_SET_D3      = 4'd1,
    S_SET_D2      = 4'd2,
    S_SET_D1      = 4'd3,
    S_SET_D0      = 4'd4,
    S_GUESS_D3    = 4'd5,
    S_GUESS_D2    = 4'd6,
    S_GUESS_D1    = 4'd7,
    S_GUESS_D0    = 4'd8,
    S_SHOW_RESULT = 4'd9,
    S_WIN         = 4'd10,
    S_LOSE        = 4'd11
  } state_t;

  // Digit slot being entered in a SET/GUESS state (3 = leftmost).
  function automatic logic [1:0] digit_pos(input state_t s);
    case (s)
      S_SET_D3, S_GUESS_D3: digit_pos = 2'd3;
      S_SET_D2, S_GUESS_D2: digit_pos = 2'd2;
      S_SET_D1, S_GUESS_D1: digit_pos = 2'd1;
      default:              digit_pos = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Link between the key/switch front end, the game sequencer and the display.
// Handshake: confirm is a single-cycle strobe with no back-pressure; it is
// accepted only in the cycle where sw_valid (or the state's own rule) allows.
interface game_ctrl_if;
  import game_types::*;

  logic               confirm;
  logic [9:0]         sw;
  state_t             state;
  logic [DIGIT_W-1:0] target [3:0];
  logic [DIGIT_W-1:0] guess  [3:0];
  logic [DIGIT_W-1:0] candidate;
  logic               sw_valid;
  logic [2:0]         chances;
  logic               blink_on;

  modport master (
    input  confirm, sw,
    output state, target, guess, candidate, sw_valid, chances, blink_on
  );

  modport slave (
    output confirm, sw,
    input  state, target, guess, candidate, sw_valid, chances, blink_on
  );

endinterface

// File: rtl/game_ctrl_sw_digit_encoder.sv
// Maps the 10 slide switches to the lowest selected digit and flags whether
// exactly one switch is up.
module sw_digit_encoder
  import game_types::*;
(
  input  logic [9:0]         sw,
  output logic [DIGIT_W-1:0] candidate,
  output logic               onehot
);

  always_comb begin
    candidate = '0;
    // Descending scan so the lowest set bit is written last and wins.
    for (int i = 9; i >= 0; i--) begin
      if (sw[i]) candidate = DIGIT_W'(i);
    end
    onehot = (sw != '0) && ((sw & (sw - 10'd1)) == '0);
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: secret entry, guess entry with duplicate rejection, result
// display hold, win/lose, plus the free-running blink used by the display.
module game_ctrl
  import game_types::*;
#(
  parameter int MAX_CHANCES = DEFAULT_MAX_CHANCES,
  parameter int BLINK_DIV   = 12_500_000,
  parameter int SHOW_CYCLES = 150_000_000
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.master bus
);

  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int SHOW_W  = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [2:0]         CHANCES_INIT = 3'(MAX_CHANCES);

  state_t             state_q, state_d;
  logic [DIGIT_W-1:0] target_q [3:0];
  logic [DIGIT_W-1:0] target_d [3:0];
  logic [DIGIT_W-1:0] guess_q  [3:0];
  logic [DIGIT_W-1:0] guess_d  [3:0];
  logic [2:0]         chances_q, chances_d;
  logic               blink_q, blink_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [SHOW_W-1:0]  show_cnt_q, show_cnt_d;

  logic [DIGIT_W-1:0] candidate;
  logic               onehot;
  logic               dup;
  logic               sw_valid;
  logic               commit;
  logic [1:0]         pos;
  logic               in_set, in_guess;

  sw_digit_encoder u_enc (
    .sw        (bus.sw),
    .candidate (candidate),
    .onehot    (onehot)
  );

  // A digit may not repeat one already committed to the left of the slot.
  always_comb begin
    pos      = digit_pos(state_q);
    in_set   = (state_q >= S_SET_D3) && (state_q <= S_SET_D0);
    in_guess = (state_q >= S_GUESS_D3) && (state_q <= S_GUESS_D0);
    dup      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > int'(pos)) begin
        if (in_set   && (target_q[k] == candidate)) dup = 1'b1;
        if (in_guess && (guess_q[k]  == candidate)) dup = 1'b1;
      end
    end
    sw_valid = onehot && !dup;
    commit   = bus.confirm && sw_valid;
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    guess_d     = guess_q;
    chances_d   = chances_q;
    show_cnt_d  = show_cnt_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);

    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.confirm) state_d = S_SET_D3;
      end
      S_SET_D3, S_SET_D2, S_SET_D1: begin
        if (commit) begin
          target_d[pos] = candidate;
          state_d       = state_t'(state_q + 4'd1);
        end
      end
      S_SET_D0: begin
        if (commit) begin
          target_d[0] = candidate;
          state_d     = S_GUESS_D3;
          chances_d   = CHANCES_INIT;
        end
      end
      S_GUESS_D3, S_GUESS_D2, S_GUESS_D1: begin
        if (commit) begin
          guess_d[pos] = candidate;
          state_d      = state_t'(state_q + 4'd1);
        end
      end
      S_GUESS_D0: begin
        if (commit) begin
          guess_d[0] = candidate;
          if ((guess_q[3] == target_q[3]) && (guess_q[2] == target_q[2]) &&
              (guess_q[1] == target_q[1]) && (candidate  == target_q[0])) begin
            state_d = S_WIN;
          end else begin
            if (chances_q != 3'd0) chances_d = chances_q - 3'd1;
            state_d    = S_SHOW_RESULT;
            show_cnt_d = '0;
          end
        end
      end
      S_SHOW_RESULT: begin
        if (bus.confirm || (show_cnt_q == SHOW_LAST)) begin
          show_cnt_d = '0;
          state_d    = (chances_q == 3'd0) ? S_LOSE : S_GUESS_D3;
        end else begin
          show_cnt_d = show_cnt_q + SHOW_W'(1);
        end
      end
      S_WIN, S_LOSE: begin
        if (bus.confirm) begin
          state_d   = S_IDLE;
          chances_d = CHANCES_INIT;
        end
      end
      default: begin
        state_d   = S_IDLE;
        chances_d = CHANCES_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      target_q    <= '{default: '0};
      guess_q     <= '{default: '0};
      chances_q   <= CHANCES_INIT;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      show_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      guess_q     <= guess_d;
      chances_q   <= chances_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      show_cnt_q  <= show_cnt_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.target    = target_q;
  assign bus.guess     = guess_q;
  assign bus.chances   = chances_q;
  assign bus.blink_on  = blink_q;
  assign bus.candidate = candidate;
  assign bus.sw_valid  = sw_valid;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Game sequencer for the 4-digit distinct-digit code game; the producer side of the display controller.
- Takes a debounced confirm pulse and the 10 slide switches.
- Walks the setter through entering a secret code, then the guesser through up to MAX_CHANCES guesses.
- Drives state, target, guess, candidate, sw_valid, chances and blink_on, which the display controller consumes directly.

Parameters:
MAX_CHANCES, 5, guesses allowed per round (1-7, fits 3 bits)
BLINK_DIV, 12_500_000, clk cycles per blink_on half-period (>=2)
SHOW_CYCLES, 150_000_000, clk cycles S_SHOW_RESULT is held before auto-advance (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
confirm  in  1  one-cycle pulse from key debouncer
sw  in  10  slide switches; sw[i] high selects digit i
state  out  state_t  current game state (game_types)
target  out  4x4 (logic [3:0] target [3:0])  secret digits, [3] leftmost
guess  out  4x4 (logic [3:0] guess [3:0])  current guess digits, [3] leftmost
candidate  out  4  digit currently selected on sw
sw_valid  out  1  candidate may be committed this cycle
chances  out  3  guesses remaining
blink_on  out  1  free-running blink square wave

Behaviour:
- Reset: state=S_IDLE, target all 0, guess all 0, chances=MAX_CHANCES, blink_on=0, blink and show counters 0. rst overrides every event in the same cycle, including mid-entry and mid-show.
- All outputs except candidate and sw_valid are registered. A transition caused by confirm is visible the cycle after the pulse.
- candidate/sw_valid are combinational from sw, state, target and guess:
  - candidate = index of the lowest set bit of sw; 0 if sw==0.
  - onehot = exactly one bit of sw set.
  - In S_SET_Dn: sw_valid = onehot and candidate differs from target[3..n+1].
  - In S_GUESS_Dn: sw_valid = onehot and candidate differs from guess[3..n+1].
  - In all other states: sw_valid = onehot.
- Transitions (confirm = confirm pulse this cycle):
  - S_IDLE: confirm -> S_SET_D3.
  - S_SET_Dn: confirm && sw_valid -> target[n]<=candidate, go to S_SET_D(n-1). From S_SET_D0, go to S_GUESS_D3 and set chances<=MAX_CHANCES. confirm && !sw_valid: ignored, no change.
  - S_GUESS_Dn, n=3..1: confirm && sw_valid -> guess[n]<=candidate, go to S_GUESS_D(n-1). Invalid confirm is ignored.
  - S_GUESS_D0: confirm && sw_valid -> guess[0]<=candidate. Compare {guess[3],guess[2],guess[1],candidate} with target:
    - all four equal -> S_WIN; chances unchanged.
    - otherwise -> chances<=chances-1 and S_SHOW_RESULT; show counter cleared.
  - S_SHOW_RESULT: show counter increments each cycle. On confirm, or counter==SHOW_CYCLES-1 (whichever first): chances==0 -> S_LOSE, else -> S_GUESS_D3. Counter cleared on exit.
  - S_WIN, S_LOSE: confirm -> S_IDLE. chances reloads to MAX_CHANCES on entering S_IDLE.
- Entering S_GUESS_D3 does not clear guess; stale digits stay in the register and are masked by the display.
- chances never decrements below 0. Decrement happens only on the S_GUESS_D0 non-win commit.
- Blink: counter counts 0..BLINK_DIV-1 and wraps; blink_on toggles on the wrap. Free-running in every state, unaffected by confirm.
- Unused state_t encodings recover to S_IDLE on the next cycle.

Decomposition:
- game_types package (existing) holds state_t and gains two constants: DIGIT_W=4 and default MAX_CHANCES.
- One sub-module, sw_digit_encoder: combinational 10-bit sw -> {candidate[3:0], onehot}.
- Duplicate check, FSM and counters stay inside game_ctrl.

Test Plan:
- Reset, then confirm -> state S_IDLE->S_SET_D3, chances=5, blink_on toggles every BLINK_DIV cycles (use BLINK_DIV=4 in sim).
- Set code 1-2-3-4 (sw=0x002,0x004,0x008,0x010 with confirm each) -> target={1,2,3,4}, state S_GUESS_D3. In S_SET_D2, sw=0x002 gives sw_valid=0 and confirm leaves state unchanged. sw=0x006 gives sw_valid=0, candidate=1.
- Target 1234, guess 1243 -> S_SHOW_RESULT, chances=4. With SHOW_CYCLES=8 and no confirm, S_GUESS_D3 is reached exactly 8 cycles after entry.
- Target 1234, guess 1234 on first try -> S_WIN with chances=5; confirm -> S_IDLE.
- Five wrong guesses -> chances 4,3,2,1,0. Confirm in final S_SHOW_RESULT -> S_LOSE; confirm -> S_IDLE, chances=5.
- Assert rst in S_GUESS_D1 together with a valid confirm -> next cycle S_IDLE, guess/target all 0, blink_on=0.
